// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: state encoding, saved-context record and
// a per-stage enable decode helper.
package pipe_ctrl_pkg;

  localparam int MAX_STAGES = 8;
  localparam int W_BITS     = 4;
  localparam int S_BITS     = 3;
  localparam int PERF_W     = 32;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    WARMUP = 3'd1,
    RUN    = 3'd2,
    STALL  = 3'd3,
    PAUSE  = 3'd4,
    HALT   = 3'd5
  } pipe_state_t;

  typedef struct packed {
    pipe_state_t         state;
    logic [W_BITS-1:0]   w;
    logic [S_BITS-1:0]   s;
  } pipe_ctx_t;

  localparam pipe_ctx_t CTX_RESET = '{state: INIT, w: 4'd0, s: 3'd0};

  // Enable for one stage index given the current context.
  function automatic logic stage_on(input pipe_ctx_t ctx, input int idx, input int stall_stage);
    logic on;
    case (ctx.state)
      WARMUP:  on = (W_BITS'(idx) < ctx.w);
      RUN:     on = 1'b1;
      STALL:   on = (idx >= stall_stage);
      default: on = 1'b0;
    endcase
    return on;
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// 32-bit event counter that saturates at all-ones instead of wrapping.
module pipe_perf_cnt
  import pipe_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clear,
  output logic [PERF_W-1:0] cnt
);

  logic [PERF_W-1:0] cnt_r;

  // Count register with saturation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {PERF_W{1'b0}};
    end else if (clear) begin
      cnt_r <= {PERF_W{1'b0}};
    end else if (inc && (cnt_r != {PERF_W{1'b1}})) begin
      cnt_r <= cnt_r + PERF_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: warm-up, load stalls, pause/resume, halt.
// Performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES   = 4,
  parameter int STALL_STAGE  = 2,
  parameter int STALL_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_req,
  input  logic                  stall_req,
  input  logic                  pause_req,
  input  logic                  halt_req,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  pause_ack,
  output logic                  halted,
  output logic [2:0]            state_o,
  output logic [31:0]           perf_stall,
  output logic [31:0]           perf_flush,
  output logic [31:0]           perf_pause
);

  pipe_ctx_t cur_r, nxt_s;
  pipe_ctx_t saved_r, saved_nxt_s;
  logic [NUM_STAGES-1:0] stage_en_s;

  // Current and saved context registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_r   <= CTX_RESET;
      saved_r <= CTX_RESET;
    end else begin
      cur_r   <= nxt_s;
      saved_r <= saved_nxt_s;
    end
  end

  // Next context: halt > flush > pause > stall > normal progression.
  always_comb begin
    nxt_s       = cur_r;
    saved_nxt_s = saved_r;
    if (cur_r.state == HALT) begin
      nxt_s = cur_r;
    end else if (halt_req) begin
      nxt_s.state = HALT;
    end else if (flush_req) begin
      nxt_s       = CTX_RESET;
      saved_nxt_s = CTX_RESET;
    end else if (pause_req) begin
      if (cur_r.state != PAUSE) begin
        saved_nxt_s = cur_r;
        nxt_s.state = PAUSE;
      end else begin
        nxt_s = cur_r;
      end
    end else if (cur_r.state == PAUSE) begin
      // Resume exactly where the pause interrupted.
      nxt_s = saved_r;
    end else if (stall_req && (cur_r.state == RUN)) begin
      nxt_s.state = STALL;
      nxt_s.s     = S_BITS'(STALL_CYCLES);
    end else begin
      case (cur_r.state)
        INIT: begin
          nxt_s.state = WARMUP;
          nxt_s.w     = 4'd1;
        end
        WARMUP: begin
          if (cur_r.w == W_BITS'(NUM_STAGES - 1)) begin
            nxt_s.state = RUN;
          end else begin
            nxt_s.w = cur_r.w + 4'd1;
          end
        end
        STALL: begin
          nxt_s.s = cur_r.s - 3'd1;
          if (cur_r.s == 3'd1) begin
            nxt_s.state = RUN;
          end else begin
            nxt_s.state = STALL;
          end
        end
        default: nxt_s = cur_r;
      endcase
    end
  end

  // Per-stage enable decode from the registered context.
  always_comb begin
    stage_en_s = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      stage_en_s[i] = stage_on(cur_r, i, STALL_STAGE);
    end
  end

  assign stage_en  = stage_en_s;
  assign state_o   = cur_r.state;
  assign pause_ack = (cur_r.state == PAUSE);
  assign halted    = (cur_r.state == HALT);

`ifdef PIPE_CTRL_PERF_EN
  logic flush_acc_s;
  assign flush_acc_s = flush_req && !halt_req && (cur_r.state != HALT);

  pipe_perf_cnt u_perf_stall (
    .clk   (clk),
    .rst   (rst),
    .inc   (cur_r.state == STALL),
    .clear (1'b0),
    .cnt   (perf_stall)
  );

  pipe_perf_cnt u_perf_flush (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_acc_s),
    .clear (1'b0),
    .cnt   (perf_flush)
  );

  pipe_perf_cnt u_perf_pause (
    .clk   (clk),
    .rst   (rst),
    .inc   (cur_r.state == PAUSE),
    .clear (1'b0),
    .cnt   (perf_pause)
  );
`else
  assign perf_stall = 32'd0;
  assign perf_flush = 32'd0;
  assign perf_pause = 32'd0;
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4: pipeline stage count, range 2..8; bit 0 is fetch.
REQ-002 SHALL have parameter STALL_STAGE, default 2: lowest stage index kept running during a load stall, range 1..NUM_STAGES-1.
REQ-003 SHALL have parameter STALL_CYCLES, default 1: load-stall length in cycles, range 1..7.
REQ-004 SHALL use one clock and an asynchronous active-low reset, with these ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- flush_req  in  1  taken jump or branch from execute.
- stall_req  in  1  load-use hazard from decode.
- pause_req  in  1  external freeze request (level).
- halt_req  in  1  halt instruction retired.
- stage_en  out  NUM_STAGES  per-stage enable.
- pause_ack  out  1  high while in PAUSE.
- halted  out  1  high while in HALT.
- state_o  out  3  current pipe_state_t.
- perf_stall  out  32  stall-cycle counter.
- perf_flush  out  32  flush-event counter.
- perf_pause  out  32  pause-cycle counter.

Function
REQ-005 SHALL hold registered states INIT, WARMUP, RUN, STALL, PAUSE, HALT, plus a warm-up counter w, a stall counter s, and a saved-state register.
REQ-006 SHALL decode stage_en combinationally from the registered state, with zero-cycle latency to state:
- INIT and HALT: all zeros.
- WARMUP: stages 0..w-1 enabled.
- RUN: all ones.
- STALL: stages STALL_STAGE..NUM_STAGES-1 enabled.
- PAUSE: all zeros.
REQ-007 SHALL evaluate next-state priority per cycle as halt_req > flush_req > pause_req > stall_req > normal progression.
REQ-008 SHALL progress normally as:
- INIT to WARMUP with w=1.
- WARMUP increments w; when w==NUM_STAGES-1, goes to RUN.
- RUN stays in RUN.
- STALL decrements s; when s==1, goes to RUN.
REQ-009 SHALL, for flush_req from any state except HALT, go to INIT next cycle; this covers WARMUP, STALL and PAUSE, and a saved state is discarded.
REQ-010 SHALL honour stall_req only in RUN: go to STALL with s=STALL_CYCLES; stall_req is ignored in INIT, WARMUP, STALL and PAUSE.
REQ-011 SHALL handle pause_req as follows:
- In INIT, WARMUP, RUN or STALL: save state, w and s, then enter PAUSE.
- Remain in PAUSE while pause_req is high.
- On deassertion, restore the saved state, w and s exactly, with no cycle lost or repeated.
REQ-012 SHALL make HALT sticky; only reset exits HALT, and all requests are ignored there.
REQ-013 SHALL let simultaneous flush_req and stall_req in RUN resolve to INIT; the stall is dropped.
REQ-014 SHALL drive pause_ack = (state==PAUSE) and halted = (state==HALT), both combinational from the registered state.

Reset
REQ-015 SHALL, on rst low and asynchronously, set the following regardless of the clock:
- state INIT, w=0, s=0, saved state INIT.
- stage_en 0, pause_ack 0, halted 0.
- All perf counters 0.
REQ-016 SHALL let reset asserted mid-operation (any state, including PAUSE and HALT) take effect immediately; after release, the first rising edge moves to WARMUP.

Configuration
REQ-017 SHALL, with PIPE_CTRL_PERF_EN defined, run three 32-bit counters that saturate at 0xFFFFFFFF (no wrap):
- perf_stall increments each cycle in STALL.
- perf_flush increments each cycle in which flush_req is accepted.
- perf_pause increments each cycle in PAUSE.
REQ-018 SHALL, with PIPE_CTRL_PERF_EN undefined, keep the perf ports present but tied to constant 0, with no counter flops.

Structure
REQ-019 SHALL place the pipe_state_t enum (3-bit, INIT=0, WARMUP=1, RUN=2, STALL=3, PAUSE=4, HALT=5) in shared package pipe_ctrl_pkg, alongside other pipeline typedefs.
REQ-020 SHALL implement the saturating counter as sub-module pipe_perf_cnt (inputs inc and clear, 32-bit output), instantiated three times under PIPE_CTRL_PERF_EN.

Verification
REQ-021 SHALL cover, with defaults, release reset and apply no requests: stage_en SHALL read 0000, 0001, 0011, 0111, then 1111 from cycle 4 onward.
REQ-022 SHALL cover, in RUN with STALL_CYCLES=2, pulsing stall_req for one cycle: stage_en SHALL be 1100 for 2 cycles, then 1111, and perf_stall SHALL equal 2.
REQ-023 SHALL cover, in WARMUP w=2, asserting flush_req and stall_req together: the next state SHALL be INIT with stage_en 0000, and perf_flush SHALL equal 1.
REQ-024 SHALL cover, in STALL s=2, holding pause_req high for 5 cycles: pause_ack SHALL be high for 5 cycles, the state SHALL resume as STALL s=2, and perf_pause SHALL equal 5.
REQ-025 SHALL cover halt_req in RUN followed by flush_req and pause_req: halted SHALL stay 1 and stage_en 0000 until rst is pulsed low mid-cycle, at which point all outputs SHALL clear asynchronously.
REQ-026 SHALL cover, with the perf counter preloaded via force to 0xFFFFFFFE, three stall cycles: the counter SHALL hold at 0xFFFFFFFF.
